// File: rtl/wb_mon_pkg.sv
// Shared types and error-bit indices for the Wishbone protocol monitor.
package wb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CYC  = 2'd1,
        WAIT = 2'd2
    } wb_mon_state_t;

    localparam int E_STB_NO_CYC = 0;
    localparam int E_ACK_STRAY  = 1;
    localparam int E_TIMEOUT    = 2;
    localparam int E_UNSTABLE   = 3;
    localparam int E_SEL_ZERO   = 4;
    localparam int NUM_ERR      = 5;

endpackage

// File: rtl/wb_mon_channel.sv
// One monitored Wishbone port: beat FSM, ack wait counter, held we/sel,
// sticky error flags and a saturating completed-beat counter.
module wb_mon_channel
    import wb_mon_pkg::*;
#(
    parameter int SEL_W       = 4,
    parameter int ACK_TIMEOUT = 256,
    parameter int CNT_W       = 16,
    parameter int CHECK_SEL   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic               we_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               ack_i,
    input  logic               clr_i,
    output logic [NUM_ERR-1:0] flags_o,
    output logic [NUM_ERR-1:0] set_o,
    output logic [NUM_ERR-1:0] flags_next_o,
    output logic [CNT_W-1:0]   beat_cnt_o
);

    localparam int WCNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TO_MAX  = WCNT_W'(ACK_TIMEOUT);
    localparam logic [WCNT_W-1:0] TO_LAST = WCNT_W'(ACK_TIMEOUT - 1);

    wb_mon_state_t      state_q;
    logic [WCNT_W-1:0]  wcnt_q;
    logic               we_q;
    logic [SEL_W-1:0]   sel_q;
    logic [NUM_ERR-1:0] flags_q, flags_d, set;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic               active, pending;

    // Violations seen this cycle, and the next sticky flag value (set beats clear)
    always_comb begin
        active  = stb_i & cyc_i;
        pending = (state_q == WAIT) & active & ~ack_i;
        set     = '0;
        set[E_STB_NO_CYC] = stb_i & ~cyc_i;
        set[E_ACK_STRAY]  = ack_i & ~active;
        set[E_TIMEOUT]    = pending & (wcnt_q == TO_LAST);
        set[E_UNSTABLE]   = pending & ((we_i != we_q) | (sel_i != sel_q));
        set[E_SEL_ZERO]   = (CHECK_SEL != 0) & active & (sel_i == '0);
        flags_d = (clr_i ? '0 : flags_q) | set;
    end

    // Beat FSM, wait counter, held attributes, flags and beat counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            flags_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            flags_q <= flags_d;
            if (active && ack_i && (beat_cnt_q != '1))
                beat_cnt_q <= beat_cnt_q + 1'b1;
            if (!cyc_i) begin
                state_q <= IDLE;                 // master abort is legal
            end else if (!stb_i || ack_i) begin
                state_q <= CYC;                  // any further stb is a fresh beat
            end else if (state_q != WAIT) begin
                state_q <= WAIT;
                wcnt_q  <= {{(WCNT_W-1){1'b0}}, 1'b1};
                we_q    <= we_i;
                sel_q   <= sel_i;
            end else if (wcnt_q != TO_MAX) begin
                wcnt_q  <= wcnt_q + 1'b1;        // holds at the limit: timeout fires once
            end
        end
    end

    assign flags_o      = flags_q;
    assign set_o        = set;
    assign flags_next_o = flags_d;
    assign beat_cnt_o   = beat_cnt_q;

endmodule

// File: rtl/wb_protocol_monitor.sv
// Multi-channel passive Wishbone B3 protocol monitor: per-channel checkers,
// interrupt OR-reduce and first-error capture with lowest-channel priority.
module wb_protocol_monitor
    import wb_mon_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SEL_W       = 4,
    parameter int ACK_TIMEOUT = 256,
    parameter int CNT_W       = 16,
    parameter int CHECK_SEL   = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_CH-1:0]         wb_cyc_i,
    input  logic [NUM_CH-1:0]         wb_stb_i,
    input  logic [NUM_CH-1:0]         wb_we_i,
    input  logic [NUM_CH*SEL_W-1:0]   wb_sel_i,
    input  logic [NUM_CH-1:0]         wb_ack_i,
    input  logic                      err_clr_i,
    output logic [NUM_CH*NUM_ERR-1:0] err_flags_o,
    output logic                      err_irq_o,
    output logic                      err_first_vld_o,
    output logic [CH_W-1:0]           err_first_ch_o,
    output logic [NUM_ERR-1:0]        err_first_code_o,
    output logic [NUM_CH*CNT_W-1:0]   beat_cnt_o
);

    logic [NUM_CH-1:0][NUM_ERR-1:0] ch_set, ch_next;
    logic                           any_set;
    logic [CH_W-1:0]                pick_ch;
    logic [NUM_ERR-1:0]             pick_code;
    logic                           irq_q, first_vld_q;
    logic [CH_W-1:0]                first_ch_q;
    logic [NUM_ERR-1:0]             first_code_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wb_mon_channel #(
            .SEL_W      (SEL_W),
            .ACK_TIMEOUT(ACK_TIMEOUT),
            .CNT_W      (CNT_W),
            .CHECK_SEL  (CHECK_SEL)
        ) u_ch (
            .clk_i       (wb_clk_i),
            .rst_i       (wb_rst_i),
            .cyc_i       (wb_cyc_i[g]),
            .stb_i       (wb_stb_i[g]),
            .we_i        (wb_we_i[g]),
            .sel_i       (wb_sel_i[g*SEL_W +: SEL_W]),
            .ack_i       (wb_ack_i[g]),
            .clr_i       (err_clr_i),
            .flags_o     (err_flags_o[g*NUM_ERR +: NUM_ERR]),
            .set_o       (ch_set[g]),
            .flags_next_o(ch_next[g]),
            .beat_cnt_o  (beat_cnt_o[g*CNT_W +: CNT_W])
        );
    end

    // Priority pick of the lowest channel raising a flag this cycle
    always_comb begin
        any_set   = 1'b0;
        pick_ch   = '0;
        pick_code = '0;
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (|ch_set[n]) begin
                any_set   = 1'b1;
                pick_ch   = CH_W'(n);
                pick_code = ch_next[n];
            end
        end
    end

    // Interrupt lags the flags by one cycle; capture reloads if set collides with clear
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_q        <= 1'b0;
            first_vld_q  <= 1'b0;
            first_ch_q   <= '0;
            first_code_q <= '0;
        end else begin
            irq_q <= |err_flags_o;
            if (any_set && (!first_vld_q || err_clr_i)) begin
                first_vld_q  <= 1'b1;
                first_ch_q   <= pick_ch;
                first_code_q <= pick_code;
            end else if (err_clr_i) begin
                first_vld_q  <= 1'b0;
                first_ch_q   <= '0;
                first_code_q <= '0;
            end
        end
    end

    assign err_irq_o        = irq_q;
    assign err_first_vld_o  = first_vld_q;
    assign err_first_ch_o   = first_ch_q;
    assign err_first_code_o = first_code_q;

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Directed table-driven bench for wb_protocol_monitor (4 channels, defaults).
module tb_wb_protocol_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cyc, stb, we, ack;
    logic [15:0] sel;
    logic        clr;
    logic [19:0] flags;
    logic        irq, fvld;
    logic [1:0]  fch;
    logic [4:0]  fcode;
    logic [63:0] beats;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_protocol_monitor dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .wb_cyc_i        (cyc),
        .wb_stb_i        (stb),
        .wb_we_i         (we),
        .wb_sel_i        (sel),
        .wb_ack_i        (ack),
        .err_clr_i       (clr),
        .err_flags_o     (flags),
        .err_irq_o       (irq),
        .err_first_vld_o (fvld),
        .err_first_ch_o  (fch),
        .err_first_code_o(fcode),
        .beat_cnt_o      (beats)
    );

    typedef struct {
        logic [3:0]  cyc, stb, we;
        logic [15:0] sel;
        logic [3:0]  ack;
        logic        clr;
        logic [19:0] flags;
        logic        irq, vld;
        logic [1:0]  ch;
        logic [4:0]  code;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [3:0] c, logic [3:0] s, logic [3:0] w, logic [15:0] sl,
                                logic [3:0] a, logic cl, logic [19:0] f, logic i, logic v,
                                logic [1:0] ch, logic [4:0] cd);
        vec_t r;
        r.cyc = c; r.stb = s; r.we = w; r.sel = sl; r.ack = a; r.clr = cl;
        r.flags = f; r.irq = i; r.vld = v; r.ch = ch; r.code = cd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [19:0] f, input logic i, input logic v,
                           input logic [1:0] ch, input logic [4:0] cd);
        chk({tag, " flags"}, 64'(flags), 64'(f));
        chk({tag, " irq"},   64'(irq),   64'(i));
        chk({tag, " vld"},   64'(fvld),  64'(v));
        chk({tag, " ch"},    64'(fch),   64'(ch));
        chk({tag, " code"},  64'(fcode), 64'(cd));
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] s, input logic [3:0] w,
                         input logic [15:0] sl, input logic [3:0] a, input logic cl);
        cyc = c; stb = s; we = w; sel = sl; ack = a; clr = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        // clean write on ch0, ack on the third cycle
        tv.push_back(mk(4'h1, 4'h1, 4'h1, 16'h000F, 4'h0, 0, 20'h00000, 0, 0, 0, 5'h00));
        tv.push_back(mk(4'h1, 4'h1, 4'h1, 16'h000F, 4'h0, 0, 20'h00000, 0, 0, 0, 5'h00));
        tv.push_back(mk(4'h1, 4'h1, 4'h1, 16'h000F, 4'h1, 0, 20'h00000, 0, 0, 0, 5'h00));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 0, 20'h00000, 0, 0, 0, 5'h00));
        // ch2 stb without cyc; irq one cycle behind the flag
        tv.push_back(mk(4'h0, 4'h4, 4'h0, 16'h0000, 4'h0, 0, 20'h00400, 0, 1, 2, 5'h01));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 0, 20'h00400, 1, 1, 2, 5'h01));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1, 20'h00000, 1, 0, 0, 5'h00));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 0, 20'h00000, 0, 0, 0, 5'h00));
        // ch3 sel F->3 mid-wait together with stray ack on ch1: ch1 captured
        tv.push_back(mk(4'h8, 4'h8, 4'h0, 16'hF000, 4'h0, 0, 20'h00000, 0, 0, 0, 5'h00));
        tv.push_back(mk(4'h8, 4'h8, 4'h0, 16'h3000, 4'h2, 0, 20'h40040, 0, 1, 1, 5'h02));
        tv.push_back(mk(4'h8, 4'h8, 4'h0, 16'h3000, 4'h8, 0, 20'h40040, 1, 1, 1, 5'h02));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 0, 20'h40040, 1, 1, 1, 5'h02));
        // clear colliding with new ch0 stb-without-cyc: set wins, capture reloads
        tv.push_back(mk(4'h0, 4'h1, 4'h0, 16'h0000, 4'h0, 1, 20'h00001, 1, 1, 0, 5'h01));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1, 20'h00000, 1, 0, 0, 5'h00));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 0, 20'h00000, 0, 0, 0, 5'h00));
        // ch1 strobe with sel==0
        tv.push_back(mk(4'h2, 4'h2, 4'h0, 16'h0000, 4'h0, 0, 20'h00200, 0, 1, 1, 5'h10));
        tv.push_back(mk(4'h2, 4'h2, 4'h0, 16'h0000, 4'h2, 0, 20'h00200, 1, 1, 1, 5'h10));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1, 20'h00000, 1, 0, 0, 5'h00));
        tv.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 0, 20'h00000, 0, 0, 0, 5'h00));

        tick(); tick();
        rst = 1'b0;
        chk_all("reset", 20'h0, 0, 0, 0, 5'h0);
        chk("reset beats", beats, 64'h0);

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].cyc, tv[k].stb, tv[k].we, tv[k].sel, tv[k].ack, tv[k].clr);
            tick();
            chk_all($sformatf("vec%0d", k), tv[k].flags, tv[k].irq, tv[k].vld, tv[k].ch, tv[k].code);
        end
        chk("table beats", beats, {16'd1, 16'd0, 16'd1, 16'd1});

        // ch1 waits 300 cycles: timeout on the 256th, ack at the 300th
        for (int i = 1; i <= 300; i++) begin
            drive(4'h2, 4'h2, 4'h0, 16'h00F0, (i == 300) ? 4'h2 : 4'h0, 0);
            tick();
            if (i == 255 || i == 256 || i == 257 || i == 300)
                chk($sformatf("timeout flags @%0d", i), 64'(flags), (i >= 256) ? 64'h80 : 64'h0);
            if (i == 256) chk("timeout irq @256", 64'(irq), 64'h0);
            if (i == 257) chk("timeout irq @257", 64'(irq), 64'h1);
        end
        chk("timeout capture ch", 64'(fch), 64'h1);
        chk("timeout capture code", 64'(fcode), 64'h04);
        chk("timeout beats", beats, {16'd1, 16'd0, 16'd2, 16'd1});
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_all("after clr", 20'h0, 0, 0, 0, 5'h0);

        // reset mid-wait on every channel, then long idle
        drive(4'hF, 4'hF, 4'h0, 16'hFFFF, 4'h0, 0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk_all("mid reset", 20'h0, 0, 0, 0, 5'h0);
        chk("mid reset beats", beats, 64'h0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (300) tick();
        chk_all("post reset idle", 20'h0, 0, 0, 0, 5'h0);

        // pipelined 4-beat burst on ch2
        drive(4'h4, 4'h4, 4'h4, 16'h0F00, 4'h4, 0);
        repeat (4) tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("burst beats", beats, {16'd0, 16'd4, 16'd0, 16'd0});
        tick();
        chk_all("burst", 20'h0, 0, 0, 0, 5'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
